// File: rtl/fpu_mem_pkg.sv
// ============================================================================
// fpu_mem_pkg : shared types and defaults for the FPU operand memory server
// Rev 1.0
// ============================================================================
`default_nettype none

package fpu_mem_pkg;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;
  localparam int PORT_C = 2;
  localparam int PORT_D = 3;

  localparam int AW_DEF = 23;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } srv_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin grant, first requester at or after the pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NPORTS = 4,
  parameter int IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [NPORTS-1:0] req_i,
  input  logic              upd_i,
  input  logic [IW-1:0]     upd_idx_i,
  output logic              gnt_valid_o,
  output logic [IW-1:0]     gnt_idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;

  // Scan from the far end so the candidate closest to the pointer wins last.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NPORTS);
      if (req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = (upd_idx_i == IW'(NPORTS - 1)) ? '0 : upd_idx_i + IW'(1);
  end

  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      ptr_q <= '0;
    end else if (upd_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_mem_port_server.sv
// ============================================================================
// fpu_mem_port_server : arbitrates FPU operand handles onto one SRAM port
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_mem_port_server
  import fpu_mem_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [NPORTS-1:0]          req_avail,
  input  logic [NPORTS-1:0]          req_w_en,
  input  logic [NPORTS-1:0]          req_r_en,
  input  logic [NPORTS-1:0][AW-1:0]  req_ptr,
  input  logic [NPORTS-1:0][AW-1:0]  req_region_begin,
  input  logic [NPORTS-1:0][AW-1:0]  req_region_end,
  input  logic [NPORTS-1:0][DW-1:0]  req_data_store,
  output logic [NPORTS-1:0]          resp_done,
  output logic [NPORTS-1:0][DW-1:0]  resp_data_load,
  output logic [NPORTS-1:0]          resp_err,
  output logic [AW-1:0]              mem_addr,
  output logic                       mem_we,
  output logic                       mem_re,
  output logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = 3;

  srv_state_t                state_q;
  logic [IW-1:0]             gnt_q;
  logic                      wr_q;
  logic                      rd_q;
  logic                      oor_q;
  logic [DW-1:0]             data_q;
  logic [CW-1:0]             cnt_q;
  logic [NPORTS-1:0]         done_q;
  logic [NPORTS-1:0]         err_q;
  logic [NPORTS-1:0][DW-1:0] load_q;
  logic [AW-1:0]             addr_q;
  logic                      we_q;
  logic                      re_q;
  logic [DW-1:0]             wdata_q;

  logic [NPORTS-1:0]         pending;
  logic                      gnt_valid;
  logic [IW-1:0]             gnt_idx;
  logic [AW:0]               sum;
  logic [AW-1:0]             phys;
  logic                      oor;

  assign pending = req_avail & (req_w_en | req_r_en) & ~done_q;

  rr_arbiter #(
    .NPORTS (NPORTS),
    .IW     (IW)
  ) u_arb (
    .clk         (clk),
    .rst_l       (rst_l),
    .req_i       (pending),
    .upd_i       (state_q == RESP),
    .upd_idx_i   (gnt_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // The extra sum bit catches pointers that wrap the address space.
  always_comb begin
    sum  = {1'b0, req_region_begin[gnt_idx]} + {1'b0, req_ptr[gnt_idx]};
    phys = sum[AW-1:0];
    oor  = sum[AW] | (phys > req_region_end[gnt_idx]);
  end

  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      oor_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      load_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
        if (!req_avail[i]) done_q[i] <= 1'b0;
      end

      // Strobes are registered on the grant edge so they appear in ISSUE.
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            gnt_q   <= gnt_idx;
            wr_q    <= req_w_en[gnt_idx];
            rd_q    <= req_r_en[gnt_idx];
            data_q  <= req_data_store[gnt_idx];
            oor_q   <= oor;
            if (!oor) begin
              addr_q  <= phys;
              we_q    <= req_w_en[gnt_idx];
              re_q    <= req_r_en[gnt_idx] & ~req_w_en[gnt_idx];
              wdata_q <= req_data_store[gnt_idx];
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (oor_q) begin
            err_q[gnt_q]  <= 1'b1;
            done_q[gnt_q] <= 1'b1;
            state_q       <= RESP;
          end else if (wr_q) begin
            if (rd_q) load_q[gnt_q] <= data_q;
            done_q[gnt_q] <= 1'b1;
            state_q       <= RESP;
          end else begin
            cnt_q   <= CW'(RD_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            load_q[gnt_q] <= mem_rdata;
            done_q[gnt_q] <= 1'b1;
            state_q       <= RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_done      = done_q;
  assign resp_data_load = load_q;
  assign resp_err       = err_q;
  assign mem_addr       = addr_q;
  assign mem_we         = we_q;
  assign mem_re         = re_q;
  assign mem_wdata      = wdata_q;

endmodule

`default_nettype wire
